// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, limits and state encoding for the psum accumulator
package mac_pkg;

  localparam int SUM_W       = 20;
  localparam int EXP_W       = 5;
  localparam int EXP_MAX_VAL = 31;
  localparam int MANT_MSB    = 14;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    NORM = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - beat input and normalized result handshake bundle
interface psum_accumulator_if #(
  parameter int MANT_W = 16
);
  import mac_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [SUM_W-1:0]         signed_sum;
  logic [EXP_W-1:0]         exp_max;
  logic [EXP_W-1:0]         exp_bias;
  logic                     clear;
  logic                     out_valid;
  logic                     out_ready;
  logic [MANT_W-1:0]        out_mant;
  logic [EXP_W-1:0]         out_exp;
  logic                     out_zero;
  logic                     out_ovf;
  logic                     out_unf;

  modport slave (
    input  in_valid, signed_sum, exp_max, exp_bias, clear, out_ready,
    output in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf, out_unf
  );

  modport master (
    output in_valid, signed_sum, exp_max, exp_bias, clear, out_ready,
    input  in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf, out_unf
  );

endinterface

// File: rtl/psum_accumulator_leading_one_detector.sv
// rtl/psum_accumulator_leading_one_detector.sv - index of the most significant set bit
module leading_one_detector #(
  parameter int W     = 32,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             zero_o
);

  // Scanning upward lets the highest set bit overwrite earlier hits.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < W; i++) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign zero_o = ~|vec_i;

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - block-floating beat accumulator with normalization to mantissa/exponent
module psum_accumulator
  import mac_pkg::*;
#(
  parameter int NUM_BEATS = 4,
  parameter int ACC_W     = 32,
  parameter int MANT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  psum_accumulator_if.slave   bus
);

  localparam int CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int IDX_W = $clog2(ACC_W);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(NUM_BEATS - 1);
  localparam logic signed [7:0] EXP_CEIL  = EXP_MAX_VAL[7:0];
  localparam logic [MANT_W-1:0] MANT_SAT  = {1'b0, {(MANT_W-1){1'b1}}};

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [EXP_W-1:0]          acc_exp_q, acc_exp_d;
  logic [EXP_W-1:0]          bias_q, bias_d;
  logic                      out_valid_q, out_valid_d;
  logic [MANT_W-1:0]         out_mant_q, out_mant_d;
  logic [EXP_W-1:0]          out_exp_q, out_exp_d;
  logic                      out_zero_q, out_zero_d;
  logic                      out_ovf_q, out_ovf_d;
  logic                      out_unf_q, out_unf_d;

  logic                      in_ready;
  logic                      accept;
  logic signed [ACC_W-1:0]   sum_ext;
  logic                      exp_up;
  logic [EXP_W-1:0]          shamt;
  logic signed [ACC_W-1:0]   acc_shr;
  logic signed [ACC_W-1:0]   sum_shr;
  logic signed [ACC_W-1:0]   acc_aligned;

  logic [ACC_W-1:0]          mag;
  logic [IDX_W-1:0]          lead_idx;
  logic                      mag_zero;
  logic [ACC_W-1:0]          mag_shifted;
  logic [MANT_W-1:0]         mant_mag;
  logic signed [7:0]         norm_exp;

  assign in_ready = (state_q == ACC) && !rst;
  // clear has priority over a beat arriving in the same cycle
  assign accept   = bus.in_valid && in_ready && !bus.clear;

  assign sum_ext     = {{(ACC_W-SUM_W){bus.signed_sum[SUM_W-1]}}, bus.signed_sum};
  assign exp_up      = bus.exp_max > acc_exp_q;
  assign shamt       = exp_up ? (bus.exp_max - acc_exp_q) : (acc_exp_q - bus.exp_max);
  assign acc_shr     = acc_q >>> shamt;
  assign sum_shr     = sum_ext >>> shamt;
  assign acc_aligned = exp_up ? (acc_shr + sum_ext) : (acc_q + sum_shr);

  assign mag = acc_q[ACC_W-1] ? -acc_q : acc_q;

  leading_one_detector #(
    .W     (ACC_W),
    .IDX_W (IDX_W)
  ) u_lod (
    .vec_i  (mag),
    .idx_o  (lead_idx),
    .zero_o (mag_zero)
  );

  // Place the leading one at MANT_MSB; shifting right drops low bits.
  always_comb begin
    mag_shifted = mag;
    if (lead_idx >= IDX_W'(MANT_MSB)) mag_shifted = mag >> (lead_idx - IDX_W'(MANT_MSB));
    else                              mag_shifted = mag << (IDX_W'(MANT_MSB) - lead_idx);
  end

  assign mant_mag = mag_shifted[MANT_W-1:0];
  assign norm_exp = 8'(acc_exp_q) + 8'(lead_idx) - 8'(MANT_MSB) - 8'(bias_q);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    acc_exp_d   = acc_exp_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q;
    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    out_unf_d   = out_unf_q;

    case (state_q)
      ACC: begin
        if (bus.clear) begin
          count_d = '0;
          acc_d   = '0;
        end else if (accept) begin
          if (count_q == '0) begin
            acc_d     = sum_ext;
            acc_exp_d = bus.exp_max;
            bias_d    = bus.exp_bias;
          end else begin
            acc_d = acc_aligned;
            if (exp_up) acc_exp_d = bus.exp_max;
          end
          if (count_q == LAST_CNT) begin
            count_d = '0;
            state_d = NORM;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end

      NORM: begin
        out_valid_d = 1'b1;
        out_zero_d  = 1'b0;
        out_ovf_d   = 1'b0;
        out_unf_d   = 1'b0;
        state_d     = OUT;
        if (mag_zero) begin
          out_mant_d = '0;
          out_exp_d  = '0;
          out_zero_d = 1'b1;
        end else if (norm_exp > EXP_CEIL) begin
          out_mant_d = acc_q[ACC_W-1] ? -MANT_SAT : MANT_SAT;
          out_exp_d  = EXP_W'(EXP_MAX_VAL);
          out_ovf_d  = 1'b1;
        end else if (norm_exp[7]) begin
          out_mant_d = '0;
          out_exp_d  = '0;
          out_unf_d  = 1'b1;
        end else begin
          out_mant_d = acc_q[ACC_W-1] ? -mant_mag : mant_mag;
          out_exp_d  = norm_exp[EXP_W-1:0];
        end
      end

      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_zero_d  = 1'b0;
          out_ovf_d   = 1'b0;
          out_unf_d   = 1'b0;
          state_d     = ACC;
        end
      end

      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      count_q     <= '0;
      acc_q       <= '0;
      acc_exp_q   <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      acc_exp_q   <= acc_exp_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
      out_unf_q   <= out_unf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_mant  = out_mant_q;
  assign bus.out_exp   = out_exp_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_unf   = out_unf_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - randomized and directed check of psum_accumulator against an arithmetic model
module tb_psum_accumulator;

  localparam int NB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_accumulator_if #(.MANT_W(16)) bus ();

  psum_accumulator #(
    .NUM_BEATS (NB),
    .ACC_W     (32),
    .MANT_W    (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: schedule phase (0 collecting, 1 normalizing, 2 presenting) and group arithmetic.
  int     m_phase = 0;
  int     m_cnt   = 0;
  longint m_acc   = 0;
  int     m_exp   = 0;
  int     m_bias  = 0;
  bit     m_vld   = 0;
  int     m_mant  = 0;
  int     m_oexp  = 0;
  bit     m_z = 0, m_o = 0, m_u = 0;
  int     s_mant, s_oexp;
  bit     s_z, s_o, s_u;

  bit lit_on = 0;
  int lit_mant, lit_exp;
  bit lit_z, lit_o, lit_u;

  task automatic cmp(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic norm(input longint a, input int e0, input int b,
                      output int mant, output int oe, output bit z, output bit o, output bit u);
    longint mag, mm;
    int p, e;
    mant = 0; oe = 0; z = 0; o = 0; u = 0;
    mag = (a < 0) ? -a : a;
    if (mag == 0) begin
      z = 1;
      return;
    end
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    mm = (p >= 14) ? (mag >> (p - 14)) : (mag << (14 - p));
    e = e0 + p - 14 - b;
    if (e > 31) begin
      oe = 31; o = 1;
      mant = (a < 0) ? -32767 : 32767;
    end else if (e < 0) begin
      u = 1;
    end else begin
      oe = e;
      mant = (a < 0) ? -int'(mm) : int'(mm);
    end
  endtask

  task automatic check();
    cmp("in_ready",  bus.in_ready,  (m_phase == 0 && !rst) ? 1 : 0);
    cmp("out_valid", bus.out_valid, m_vld);
    cmp("out_mant",  $signed(bus.out_mant), m_mant);
    cmp("out_exp",   bus.out_exp,   m_oexp);
    cmp("out_zero",  bus.out_zero,  m_z);
    cmp("out_ovf",   bus.out_ovf,   m_o);
    cmp("out_unf",   bus.out_unf,   m_u);
    if (lit_on && bus.out_valid) begin
      cmp("lit_mant", $signed(bus.out_mant), lit_mant);
      cmp("lit_exp",  bus.out_exp,  lit_exp);
      cmp("lit_zero", bus.out_zero, lit_z);
      cmp("lit_ovf",  bus.out_ovf,  lit_o);
      cmp("lit_unf",  bus.out_unf,  lit_u);
      lit_on = 0;
    end
  endtask

  task automatic step(input bit v, input int s, input int e, input int b,
                      input bit c, input bit ordy, input bit r);
    @(negedge clk);
    check();
    bus.in_valid   = v;
    bus.signed_sum = s[19:0];
    bus.exp_max    = e[4:0];
    bus.exp_bias   = b[4:0];
    bus.clear      = c;
    bus.out_ready  = ordy;
    rst            = r;
    if (r) begin
      m_phase = 0; m_cnt = 0; m_acc = 0; m_exp = 0; m_bias = 0;
      m_vld = 0; m_mant = 0; m_oexp = 0; m_z = 0; m_o = 0; m_u = 0;
    end else begin
      case (m_phase)
        0: begin
          if (c) begin
            m_cnt = 0; m_acc = 0;
          end else if (v) begin
            if (m_cnt == 0) begin
              m_acc = s; m_exp = e; m_bias = b;
            end else if (e > m_exp) begin
              m_acc = (m_acc >>> (e - m_exp)) + s;
              m_exp = e;
            end else begin
              m_acc = m_acc + (longint'(s) >>> (m_exp - e));
            end
            m_cnt++;
            if (m_cnt == NB) begin
              m_cnt = 0;
              norm(m_acc, m_exp, m_bias, s_mant, s_oexp, s_z, s_o, s_u);
              m_phase = 1;
            end
          end
        end
        1: begin
          m_phase = 2; m_vld = 1;
          m_mant = s_mant; m_oexp = s_oexp; m_z = s_z; m_o = s_o; m_u = s_u;
        end
        default: begin
          if (ordy) begin
            m_phase = 0; m_vld = 0; m_z = 0; m_o = 0; m_u = 0;
          end
        end
      endcase
    end
  endtask

  task automatic set_lit(input int lm, input int le, input bit lz, input bit lo, input bit lu);
    lit_on = 1; lit_mant = lm; lit_exp = le; lit_z = lz; lit_o = lo; lit_u = lu;
  endtask

  task automatic grp(input int s0, input int s1, input int s2, input int s3,
                     input int e0, input int e1, input int e2, input int e3, input int b,
                     input int lm, input int le, input bit lz, input bit lo, input bit lu);
    set_lit(lm, le, lz, lo, lu);
    step(1, s0, e0, b, 0, 1, 0);
    step(1, s1, e1, b, 0, 1, 0);
    step(1, s2, e2, b, 0, 1, 0);
    step(1, s3, e3, b, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    int s, e, b;
    bus.in_valid = 0; bus.signed_sum = '0; bus.exp_max = '0; bus.exp_bias = '0;
    bus.clear = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);

    step(0, 0, 0, 0, 0, 1, 1);
    #1;
    cmp("reset_in_ready",  bus.in_ready, 0);
    cmp("reset_out_valid", bus.out_valid, 0);
    cmp("reset_out_mant",  bus.out_mant, 0);
    step(0, 0, 0, 0, 0, 1, 0);

    grp(100, 200, -50, 6,        10, 10, 10, 10, 0,  16384, 4, 0, 0, 0);
    grp(64, 1, 0, 0,             18, 20, 20, 20, 0,  17408, 10, 0, 0, 0);
    grp(-3, -3, -3, -3,          14, 14, 14, 14, 0, -24576, 3, 0, 0, 0);
    grp(-3, -3, -3, -3,          14, 14, 14, 14, 5,  0, 0, 0, 0, 1);
    grp(5, -5, 0, 0,             9, 9, 9, 9, 0,      0, 0, 1, 0, 0);
    grp(524287, 524287, 524287, 524287, 31, 31, 31, 31, 0, 32767, 31, 0, 1, 0);

    // Backpressure: result held while a waiting upstream beat stalls.
    set_lit(16384, 4, 0, 0, 0);
    step(1, 100, 10, 0, 0, 0, 0);
    step(1, 200, 10, 0, 0, 0, 0);
    step(1, -50, 10, 0, 0, 0, 0);
    step(1, 6,   10, 0, 0, 0, 0);
    repeat (5) step(1, 7, 3, 0, 0, 0, 0);
    repeat (3) step(1, 7, 3, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1, 0);

    // Clear drops the coincident beat; next four beats form a fresh group.
    step(1, 100, 10, 0, 0, 1, 0);
    step(1, 200, 10, 0, 0, 1, 0);
    step(1, 999, 10, 0, 1, 1, 0);
    grp(100, 200, -50, 6,        10, 10, 10, 10, 0,  16384, 4, 0, 0, 0);

    // Reset while presenting a result.
    step(1, 40, 12, 0, 0, 0, 0);
    step(1, 40, 12, 0, 0, 0, 0);
    step(1, 40, 12, 0, 0, 0, 0);
    step(1, 40, 12, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    cmp("rst_in_out_valid", bus.out_valid, 0);
    cmp("rst_in_out_mant",  bus.out_mant, 0);
    cmp("rst_in_out_exp",   bus.out_exp, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) s = int'($urandom_range(0, 200)) - 100;
      else                           s = int'($urandom_range(0, (1 << 20) - 1)) - (1 << 19);
      e = int'($urandom_range(0, 31));
      b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7));
      step($urandom_range(0, 9) < 7, s, e, b,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 299) == 0);
    end
    repeat (6) step(0, 0, 0, 0, 0, 1, 0);

    if (lit_on) begin
      n_err++;
      $display("FAIL lit_pending: got no result expected a directed result");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
